// File: rtl/sound_sequencer.sv
// sound_sequencer
// Plays short stepped-frequency melodies for a set of prioritised sound events.
// Each event has a first-note code and a per-note increment. A note lasts
// NOTE_FRAMES frame ticks, and a melody is NOTES notes long. A higher-index
// request preempts the current melody. An equal-index request restarts it.
// A lower-index request is queued in 'pending'. Between queued melodies there
// is a silent gap that lasts until the next frame tick.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   startOfFrame  in   one-cycle frame tick
//   event_pulse   in   one-cycle request per event (index NUM_EVENTS-1 = highest priority)
//   mute          in   gates enable_sound only; sequencing is unaffected
//   enable_sound  out  tone generator enable
//   freq          out  current note code
//   busy          out  sequencer not idle
//   active_event  out  index of the event now playing
//   pending       out  queued requests
//
// State table
//   IDLE | nothing playing, nothing queued
//   PLAY | melody of active_event is sounding
//   GAP  | silent gap before the next queued melody
module sound_sequencer #(
    parameter int NUM_EVENTS  = 4,
    parameter int FREQ_W      = 4,
    parameter int NOTES       = 3,
    parameter int NOTE_FRAMES = 2,
    parameter logic [NUM_EVENTS*FREQ_W-1:0] BASE_FREQ = {4'd9, 4'd5, 4'd1, 4'd3},
    parameter logic [NUM_EVENTS*FREQ_W-1:0] STEP      = {4'd1, 4'd0, 4'hF, 4'd2},
    localparam int EV_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startOfFrame,
    input  logic [NUM_EVENTS-1:0] event_pulse,
    input  logic                  mute,
    output logic                  enable_sound,
    output logic [FREQ_W-1:0]     freq,
    output logic                  busy,
    output logic [EV_W-1:0]       active_event,
    output logic [NUM_EVENTS-1:0] pending
);

    localparam int NW = (NOTES > 1) ? $clog2(NOTES) : 1;
    localparam int FW = (NOTE_FRAMES > 1) ? $clog2(NOTE_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [NW-1:0]   note_idx;
    logic [FW-1:0]   frame_cnt;

    logic [NUM_EVENTS-1:0] pend_in;
    logic [EV_W-1:0]       pulse_hi;
    logic [EV_W-1:0]       pend_hi;
    logic [EV_W-1:0]       launch_idx;
    logic                  launch;
    logic                  last_frame;
    logic                  last_note;

    function automatic logic [EV_W-1:0] hi_idx(input logic [NUM_EVENTS-1:0] v);
        logic [EV_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (v[i]) r = EV_W'(i);
        end
        return r;
    endfunction

    function automatic logic [FREQ_W-1:0] base_of(input logic [EV_W-1:0] e);
        return BASE_FREQ[int'(e)*FREQ_W +: FREQ_W];
    endfunction

    function automatic logic [FREQ_W-1:0] step_of(input logic [EV_W-1:0] e);
        return STEP[int'(e)*FREQ_W +: FREQ_W];
    endfunction

    function automatic logic [NUM_EVENTS-1:0] onehot(input logic [EV_W-1:0] e);
        return NUM_EVENTS'(1) << e;
    endfunction

    // Incoming pulses merge into the queue before any selection, so a request
    // that coincides with a finish or a gap tick is never lost. A launch always
    // wins over frame advance. This makes preempt or restart beat finish.
    // It also keeps a coincident frame tick from advancing the new melody.
    always_comb begin
        pend_in    = pending | event_pulse;
        pulse_hi   = hi_idx(event_pulse);
        pend_hi    = hi_idx(pend_in);
        last_frame = (frame_cnt == FW'(NOTE_FRAMES - 1));
        last_note  = (note_idx == NW'(NOTES - 1));
        launch     = 1'b0;
        launch_idx = pulse_hi;
        unique case (state)
            IDLE: launch = |event_pulse;
            PLAY: launch = (|event_pulse) && (pulse_hi >= active_event);
            GAP: begin
                launch     = startOfFrame && (|pend_in);
                launch_idx = pend_hi;
            end
            default: launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            note_idx     <= '0;
            frame_cnt    <= '0;
            freq         <= '0;
            active_event <= '0;
            pending      <= '0;
        end else if (launch) begin
            // A preempted event is simply dropped; only other incoming bits queue.
            state        <= PLAY;
            active_event <= launch_idx;
            note_idx     <= '0;
            frame_cnt    <= '0;
            freq         <= base_of(launch_idx);
            pending      <= pend_in & ~onehot(launch_idx);
        end else begin
            pending <= pend_in;
            unique case (state)
                IDLE: state <= IDLE;
                PLAY: begin
                    if (startOfFrame) begin
                        if (last_frame) begin
                            frame_cnt <= '0;
                            if (last_note) begin
                                state    <= (|pend_in) ? GAP : IDLE;
                                note_idx <= '0;
                                freq     <= '0;
                            end else begin
                                note_idx <= note_idx + NW'(1);
                                freq     <= freq + step_of(active_event);
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                GAP: begin
                    if (pend_in == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign enable_sound = (state == PLAY) && !mute;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer
// Directed bench for sound_sequencer with default parameters. The expected
// values are worked out by hand from the melody tables:
//   event 0: 3,5,7   event 1: 1,0,15   event 2: 5,5,5   event 3: 9,10,11
module tb_sound_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic [3:0] event_pulse = 4'b0;
    logic       mute = 1'b0;
    logic       enable_sound;
    logic [3:0] freq;
    logic       busy;
    logic [1:0] active_event;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    sound_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .event_pulse  (event_pulse),
        .mute         (mute),
        .enable_sound (enable_sound),
        .freq         (freq),
        .busy         (busy),
        .active_event (active_event),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] ev, input logic sof);
        event_pulse  = ev;
        startOfFrame = sof;
        tick();
        event_pulse  = 4'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic sofs(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, enable_sound, 0);
        chk({tag, "_freq"}, freq, 0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_en", enable_sound, 0);
        chk("rst_freq", freq, 0);
        chk("rst_act", active_event, 0);
        chk("rst_pend", pending, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // basic melody, event 0
        pulse(4'b0001, 1'b0);
        chk("basic_busy", busy, 1);
        chk("basic_en", enable_sound, 1);
        chk("basic_f0", freq, 3);
        chk("basic_act", active_event, 0);
        sofs(1);
        chk("basic_f0b", freq, 3);
        sofs(1);
        chk("basic_f1", freq, 5);
        sofs(2);
        chk("basic_f2", freq, 7);
        sofs(2);
        chk_idle("basic_end");

        // wrap-around, event 1
        pulse(4'b0010, 1'b0);
        chk("wrap_f0", freq, 1);
        sofs(2);
        chk("wrap_f1", freq, 0);
        sofs(2);
        chk("wrap_f2", freq, 15);
        sofs(2);
        chk_idle("wrap_end");

        // preempt event 0 by event 3
        pulse(4'b0001, 1'b0);
        sofs(1);
        pulse(4'b1000, 1'b0);
        chk("pre_act", active_event, 3);
        chk("pre_f0", freq, 9);
        chk("pre_pend", pending, 0);
        sofs(2);
        chk("pre_f1", freq, 10);
        sofs(2);
        chk("pre_f2", freq, 11);
        sofs(2);
        chk_idle("pre_end");

        // queue: event 2 playing, event 1 requested (twice: idempotent)
        pulse(4'b0100, 1'b0);
        chk("q_f0", freq, 5);
        pulse(4'b0010, 1'b0);
        chk("q_pend", pending, 4'b0010);
        chk("q_act", active_event, 2);
        pulse(4'b0010, 1'b0);
        chk("q_pend2", pending, 4'b0010);
        sofs(3);
        chk("q_f_mid", freq, 5);
        sofs(3);
        chk("q_gap_busy", busy, 1);
        chk("q_gap_en", enable_sound, 0);
        chk("q_gap_freq", freq, 0);
        tick();
        tick();
        chk("q_gap_hold", busy, 1);
        chk("q_gap_hold_en", enable_sound, 0);
        pulse(4'b0000, 1'b1);
        chk("q_l_act", active_event, 1);
        chk("q_l_f0", freq, 1);
        chk("q_l_pend", pending, 0);
        chk("q_l_en", enable_sound, 1);
        sofs(2);
        chk("q_l_f1", freq, 0);
        sofs(2);
        chk("q_l_f2", freq, 15);
        sofs(2);
        chk_idle("q_end");

        // simultaneous 1011 -> order 3, 1, 0
        pulse(4'b1011, 1'b0);
        chk("sim_act3", active_event, 3);
        chk("sim_pend", pending, 4'b0011);
        chk("sim_f3", freq, 9);
        sofs(6);
        chk("sim_gap1", busy, 1);
        chk("sim_gap1_en", enable_sound, 0);
        pulse(4'b0000, 1'b1);
        chk("sim_act1", active_event, 1);
        chk("sim_f1", freq, 1);
        chk("sim_pend1", pending, 4'b0001);
        sofs(6);
        chk("sim_gap2", busy, 1);
        chk("sim_gap2_f", freq, 0);
        pulse(4'b0000, 1'b1);
        chk("sim_act0", active_event, 0);
        chk("sim_f0", freq, 3);
        chk("sim_pend0", pending, 0);
        sofs(6);
        chk_idle("sim_end");

        // launch with coincident frame tick does not advance the frame count
        pulse(4'b0001, 1'b1);
        chk("co_f0", freq, 3);
        sofs(1);
        chk("co_f0b", freq, 3);
        sofs(1);
        chk("co_f1", freq, 5);
        sofs(3);
        chk("co_f2", freq, 7);
        // restart wins over finish on the last frame tick
        pulse(4'b0001, 1'b1);
        chk("rs_busy", busy, 1);
        chk("rs_f0", freq, 3);
        chk("rs_pend", pending, 0);
        sofs(6);
        chk_idle("rs_end");

        // mute during event 0
        mute = 1'b1;
        pulse(4'b0001, 1'b0);
        chk("mu_en0", enable_sound, 0);
        chk("mu_f0", freq, 3);
        chk("mu_busy", busy, 1);
        sofs(2);
        chk("mu_f1", freq, 5);
        mute = 1'b0;
        #1;
        chk("mu_unmute_en", enable_sound, 1);
        mute = 1'b1;
        sofs(2);
        chk("mu_f2", freq, 7);
        chk("mu_en2", enable_sound, 0);
        sofs(2);
        chk_idle("mu_end");
        mute = 1'b0;

        // reset mid-note with a queued request
        pulse(4'b0100, 1'b0);
        pulse(4'b0010, 1'b0);
        chk("rm_pend", pending, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_en", enable_sound, 0);
        chk("rm_freq", freq, 0);
        chk("rm_pend0", pending, 0);
        chk("rm_act", active_event, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        sofs(3);
        chk_idle("rm_after");
        pulse(4'b0001, 1'b0);
        chk("rm_restart_f", freq, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_EVENTS, default 4, number of sound-event channels; index NUM_EVENTS-1 has the highest priority.
REQ-002 Parameter FREQ_W, default 4, SHALL be the width of the frequency code.
REQ-003 Parameter NOTES, default 3, SHALL be the number of notes per event melody (range 1..16).
REQ-004 Parameter NOTE_FRAMES, default 2, SHALL be the number of frames per note (range 1..63).
REQ-005 Parameter BASE_FREQ SHALL be a packed vector of NUM_EVENTS*FREQ_W bits, default {4'd9,4'd5,4'd1,4'd3}; event e uses slice [e*FREQ_W +: FREQ_W] as its first-note code.
REQ-006 Parameter STEP SHALL be a packed vector of NUM_EVENTS*FREQ_W bits, default {4'd1,4'd0,4'hF,4'd2}; each slice is the per-note increment, added modulo 2^FREQ_W (4'hF means -1).
REQ-007 Ports SHALL be, in this order:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle frame tick
- event_pulse  in  NUM_EVENTS  one-cycle request per event
- mute  in  1  suppresses audio output only
- enable_sound  out  1  tone generator enable
- freq  out  FREQ_W  current note code
- busy  out  1  state is not IDLE
- active_event  out  EV_W  index of the event now playing, where EV_W = max(1, $clog2(NUM_EVENTS))
- pending  out  NUM_EVENTS  queued requests

Function
REQ-008 States SHALL be IDLE, PLAY and GAP; all state, counters, freq, active_event and pending SHALL be registered on posedge clk.
REQ-009 enable_sound SHALL equal (state==PLAY) && !mute; busy SHALL equal (state!=IDLE).
REQ-010 Mute SHALL NOT affect sequencing, counters or pending.
REQ-011 Launching event e SHALL set, on the next clock edge: state=PLAY, active_event=e, note_idx=0, frame_cnt=0, freq=BASE_FREQ[e], pending[e]=0.
REQ-012 In IDLE, a nonzero event_pulse SHALL launch its highest set index; the other set bits SHALL be ORed into pending.
REQ-013 In PLAY, each startOfFrame SHALL increment frame_cnt.
REQ-014 In PLAY, when startOfFrame arrives with frame_cnt==NOTE_FRAMES-1, frame_cnt SHALL go to 0 and note_idx SHALL increment.
REQ-015 On each note_idx increment, freq SHALL become freq+STEP[active_event], truncated to FREQ_W bits.
REQ-016 The melody SHALL finish on the frame boundary where note_idx==NOTES-1.
REQ-017 At finish, the state SHALL go to GAP if (pending | event_pulse) is nonzero, else to IDLE, with freq=0; a pulse arriving in the finish cycle SHALL be ORed into pending.
REQ-018 In PLAY, for the highest incoming index h: if h > active_event, SHALL preempt by launching h, dropping the old event (not queued); if h == active_event, SHALL restart by relaunching it; if h < active_event, SHALL only set pending[h]. Remaining lower bits SHALL be ORed into pending in all three cases.
REQ-019 Preempt or restart SHALL win over finish in the same cycle.
REQ-020 GAP SHALL hold enable_sound=0 and freq=0 until the next startOfFrame, then launch the highest pending bit.
REQ-021 A pulse arriving in GAP SHALL be ORed into pending before that selection.
REQ-022 If pending becomes zero while in GAP, the state SHALL return to IDLE.
REQ-023 A re-pulse of an already-pending event SHALL be idempotent (pending bit stays 1; no count).
REQ-024 A startOfFrame coincident with launch SHALL NOT advance the new melody's frame_cnt.

Reset
REQ-025 While reset=1, the block SHALL asynchronously force state=IDLE, enable_sound=0, freq=0, busy=0, active_event=0, pending=0, note_idx=0, frame_cnt=0.
REQ-026 Reset asserted mid-melody SHALL abort it and discard all pending requests; the first event after deassertion SHALL start at note 0.

Verification (default parameters)
REQ-027 Basic melody: event_pulse=4'b0001 in IDLE -> next cycle busy=1, freq=3; after SOF#2 freq=5; after SOF#4 freq=7; after SOF#6 IDLE, freq=0, enable_sound=0.
REQ-028 Wrap-around: event 1 -> freq sequence 1, 0, 15.
REQ-029 Preempt: event 0 playing, event 3 pulse -> next cycle active_event=3, freq=9, pending=0; then 9, 10, 11, then IDLE.
REQ-030 Queue: event 2 playing, event 1 pulse -> pending=4'b0010; after event 2 finishes, GAP with enable_sound=0 until the next SOF; then event 1 plays 1, 0, 15.
REQ-031 Simultaneous: event_pulse=4'b1011 in IDLE -> active_event=3, pending=4'b0011; playback order 3, 1, 0, each separated by a GAP.
REQ-032 Mute/reset: mute=1 during event 0 -> enable_sound=0 while freq steps 3, 5, 7. Reset pulse mid-note with pending=4'b0010 -> all outputs 0 immediately; no playback after release.
